// File: rtl/rf_dump_reader.sv
// Streams an inclusive, wrapping register-file address range out over valid/ready.
// Define RF_DUMP_PARITY_EN to add the out_parity output registered alongside out_data.
module rf_dump_reader #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [0:ADDR_WIDTH-1] start_addr,
  input  logic [0:ADDR_WIDTH-1] end_addr,
  output logic [0:ADDR_WIDTH-1] rdAddr,
  input  logic [0:DATA_WIDTH-1] rdData,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [0:ADDR_WIDTH-1] out_addr,
  output logic [0:DATA_WIDTH-1] out_data,
`ifdef RF_DUMP_PARITY_EN
  output logic                  out_parity,
`endif
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {StIdle, StRead, StSend, StDone} state_e;

  state_e                  state_q, state_d;
  logic [0:ADDR_WIDTH-1]   cur_q, cur_d;
  logic [0:ADDR_WIDTH-1]   last_q, last_d;
  logic [0:ADDR_WIDTH-1]   rd_addr_q, rd_addr_d;
  logic                    valid_q, valid_d;
  logic [0:ADDR_WIDTH-1]   out_addr_q, out_addr_d;
  logic [0:DATA_WIDTH-1]   out_data_q, out_data_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [0:ADDR_WIDTH-1]   cur_inc;
`ifdef RF_DUMP_PARITY_EN
  logic                    parity_q, parity_d;
`endif

  // Increment wraps naturally modulo 2**ADDR_WIDTH.
  assign cur_inc = cur_q + ADDR_WIDTH'(1);

  always_comb begin
    state_d    = state_q;
    cur_d      = cur_q;
    last_d     = last_q;
    rd_addr_d  = rd_addr_q;
    valid_d    = valid_q;
    out_addr_d = out_addr_q;
    out_data_d = out_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef RF_DUMP_PARITY_EN
    parity_d   = parity_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start && !abort) begin
          cur_d     = start_addr;
          last_d    = end_addr;
          rd_addr_d = start_addr;
          busy_d    = 1'b1;
          state_d   = StRead;
        end
      end
      StRead: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          out_data_d = rdData;
          out_addr_d = cur_q;
          valid_d    = 1'b1;
`ifdef RF_DUMP_PARITY_EN
          parity_d   = ^rdData;
`endif
          state_d    = StSend;
        end
      end
      StSend: begin
        if (abort) begin
          // A coinciding handshake still delivers this word; nothing follows it.
          valid_d = 1'b0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else if (out_ready) begin
          valid_d = 1'b0;
          if (cur_q != last_q) begin
            cur_d     = cur_inc;
            rd_addr_d = cur_inc;
            state_d   = StRead;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cur_q      <= '0;
      last_q     <= '0;
      rd_addr_q  <= '0;
      valid_q    <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef RF_DUMP_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      last_q     <= last_d;
      rd_addr_q  <= rd_addr_d;
      valid_q    <= valid_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef RF_DUMP_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign rdAddr    = rd_addr_q;
  assign out_valid = valid_q;
  assign out_addr  = out_addr_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef RF_DUMP_PARITY_EN
  assign out_parity = parity_q;
`endif

endmodule

// File: tb/tb_rf_dump_reader.sv
// Bench for rf_dump_reader: register-file model, expected-word queue and directed dump scenarios.
module tb_rf_dump_reader;

  localparam int AW = 5;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [0:AW-1] start_addr = '0;
  logic [0:AW-1] end_addr = '0;
  logic [0:AW-1] rd_addr;
  logic [0:DW-1] rd_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [0:AW-1] out_addr;
  logic [0:DW-1] out_data;
  logic          busy;
  logic          done;
`ifdef RF_DUMP_PARITY_EN
  logic          out_parity;
`endif

  logic [63:0] mem [32];
  assign rd_data = mem[rd_addr];

  typedef struct packed {
    logic [4:0]  addr;
    logic [63:0] data;
  } word_t;

  word_t      exp_q[$];
  logic [4:0] seen_addr[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         done_seen = 0;
  logic       prev_hold = 1'b0;
  logic [4:0] prev_addr;
  logic [63:0] prev_data;

  always #5 clk = ~clk;

  rf_dump_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .start_addr (start_addr),
    .end_addr   (end_addr),
    .rdAddr     (rd_addr),
    .rdData     (rd_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data),
`ifdef RF_DUMP_PARITY_EN
    .out_parity (out_parity),
`endif
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: every streamed word must be the next entry of the expected stream.
  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_addr", 64'(out_addr), 64'(prev_addr));
        check("hold_data", out_data, prev_data);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'(out_addr), 64'hffff);
        end else begin
          check("out_addr", 64'(out_addr), 64'(exp_q[0].addr));
          check("out_data", out_data, exp_q[0].data);
`ifdef RF_DUMP_PARITY_EN
          check("out_parity", 64'(out_parity), 64'(^exp_q[0].data));
`endif
          if (out_ready) begin
            seen_addr.push_back(exp_q[0].addr);
            void'(exp_q.pop_front());
          end
        end
      end
      if (done) begin
        check("done_words_pending", 64'(exp_q.size()), 64'd0);
        done_seen++;
      end
      prev_hold = out_valid && !out_ready && !abort;
      prev_addr = out_addr;
      prev_data = out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_dump(input logic [4:0] s, input logic [4:0] e);
    logic [4:0] a;
    word_t w;
    a = s;
    for (int i = 0; i < 32; i++) begin
      w.addr = a;
      w.data = mem[a];
      exp_q.push_back(w);
      if (a == e) break;
      a = a + 5'd1;
    end
    start_addr = s;
    end_addr   = e;
    start      = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    logic got;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check("wait_done_timeout", 64'(got), 64'd1);
  endtask

  task automatic wait_word(input logic [4:0] a, input int budget);
    logic got;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (out_valid && out_addr == a) begin
        got = 1'b1;
        break;
      end
    end
    check("wait_word_timeout", 64'(got), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdaddr"}, 64'(rd_addr), 64'd0);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_addr"}, 64'(out_addr), 64'd0);
    check({tag, "_data"}, out_data, 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
`ifdef RF_DUMP_PARITY_EN
    check({tag, "_parity"}, 64'(out_parity), 64'd0);
`endif
  endtask

  initial begin
    int d0;
    logic [4:0] exp_wrap [4];
    exp_wrap[0] = 5'd30;
    exp_wrap[1] = 5'd31;
    exp_wrap[2] = 5'd0;
    exp_wrap[3] = 5'd1;
    for (int i = 0; i < 32; i++) mem[i] = 64'(i);

    #1;
    check_all_zero("reset");
    tick();
    tick();
    reset = 1'b0;

    // Full dump 0..31 with literal timing of valid/busy/done.
    out_ready = 1'b1;
    start_dump(5'd0, 5'd31);
    check("t1_busy_c0", 64'(busy), 64'd1);
    check("t1_valid_c0", 64'(out_valid), 64'd0);
    check("t1_rdaddr_c0", 64'(rd_addr), 64'd0);
    for (int c = 1; c <= 65; c++) begin
      tick();
      check("t1_valid", 64'(out_valid), 64'((c <= 63) && (c % 2 == 1)));
      check("t1_busy", 64'(busy), 64'(c <= 63));
      check("t1_done", 64'(done), 64'(c == 64));
    end
    check("t1_words", 64'(seen_addr.size()), 64'd32);
    check("t1_done_count", 64'(done_seen), 64'd1);

    // Single word held by backpressure; a start while busy is ignored.
    out_ready = 1'b0;
    start_dump(5'd3, 5'd3);
    tick();
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      check("t2_valid", 64'(out_valid), 64'd1);
      check("t2_addr", 64'(out_addr), 64'd3);
      check("t2_data", out_data, 64'h03);
`ifdef RF_DUMP_PARITY_EN
      check("t2_parity", 64'(out_parity), 64'd0);
`endif
      if (i == 1) begin
        start_addr = 5'd9;
        end_addr   = 5'd9;
        start      = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    out_ready = 1'b1;
    tick();
    check("t2_done", 64'(done), 64'd1);
    check("t2_busy", 64'(busy), 64'd0);
    tick();
    check("t2_done_once", 64'(done), 64'd0);

    // start and abort together in IDLE: nothing starts.
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("t3_busy", 64'(busy), 64'd0);
    tick();
    check("t3_valid", 64'(out_valid), 64'd0);

    // Wrap-around range 30..1.
    seen_addr.delete();
    start_dump(5'd30, 5'd1);
    wait_done(20);
    check("t4_count", 64'(seen_addr.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < seen_addr.size()) check("t4_order", 64'(seen_addr[i]), 64'(exp_wrap[i]));
    end
    tick();

    // Abort while word 5 waits for ready.
    d0 = done_seen;
    start_dump(5'd0, 5'd31);
    wait_word(5'd5, 30);
    out_ready = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    exp_q.delete();
    check("t5_valid", 64'(out_valid), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 4; i++) tick();
    check("t5_no_done", 64'(done_seen), 64'(d0));
    out_ready = 1'b1;
    start_dump(5'd0, 5'd2);
    wait_done(20);
    tick();

    // Register write during SEND of word 4, then async reset mid-dump.
    start_dump(5'd0, 5'd31);
    wait_word(5'd4, 30);
    out_ready = 1'b0;
    mem[4] = 64'hffff_ffff_ffff_ffff;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_data_held", out_data, 64'h04);
    end
    out_ready = 1'b1;
    wait_word(5'd10, 30);
    #1;
    reset = 1'b1;
    #1;
    check_all_zero("t6_reset");
    exp_q.delete();
    mem[4] = 64'h04;
    tick();
    reset = 1'b0;

`ifdef RF_DUMP_PARITY_EN
    out_ready = 1'b0;
    start_dump(5'd7, 5'd7);
    tick();
    check("t7_parity", 64'(out_parity), 64'd1);
    out_ready = 1'b1;
    wait_done(5);
    tick();
`endif

    // Normal operation after reset.
    start_dump(5'd0, 5'd0);
    wait_done(10);
    check("t8_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
